ipv6_udp_chkvfy: RTL and testbench

- Receive-path counterpart of the transmit IPv6 UDP checksum pad generator in the time-stamping unit.
- Watches the 64-bit XGMII-like receive stream and accumulates the IPv6 pseudo-header, the UDP header and the UDP payload as a 16-bit ones-complement sum.
- At end of frame it reports pass or fail, so the RX timestamp path can discard PTP frames with a corrupted UDP checksum.
- Sits beside the RX PTP parser, which supplies eth_count_base_i and the header base addresses.

---
 rtl/ipv6_udp_chkvfy.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ipv6_udp_chkvfy.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv6_udp_chkvfy.sv
// ipv6_udp_chkvfy: receive-side IPv6 UDP checksum verifier.
// Accumulates pseudo-header, UDP header and payload of PTP/IPv6 frames from a
// 64-bit XGMII-like stream and reports pass/fail three enabled cycles after
// TERMINATE. All state advances only while rx_clk_en_i is high.
module ipv6_udp_chkvfy #(
  parameter bit ZERO_CHKSUM_OK = 1'b0,
  parameter int MAX_FRAME      = 2047
) (
  input  logic        rx_clk,
  input  logic        rx_rst_n,
  input  logic        rx_clk_en_i,
  input  logic        chk_en_i,
  input  logic [10:0] eth_count_base_i,
  input  logic        ipv6_flag_i,
  input  logic [10:0] ipv6_addr_base_i,
  input  logic        is_ptp_message_i,
  input  logic [63:0] rxd_i,
  input  logic [7:0]  rxc_i,
  output logic        chk_done_o,
  output logic        chk_pass_o,
  output logic        chk_fail_o,
  output logic [15:0] udp_length_o,
  output logic [15:0] rx_chksum_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCUM  = 3'd1,
    S_FOLD1  = 3'd2,
    S_FOLD2  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // per-lane decode
  logic        w_gate;
  logic        w_start;
  logic        w_term;
  logic        w_err;
  logic [11:0] w_cnt [8];
  logic [11:0] w_k   [8];
  logic [7:0]  w_dv;
  logic        w_len_hi_v;
  logic        w_len_lo_v;
  logic        w_cks_hi_v;
  logic        w_cks_lo_v;
  logic [7:0]  w_len_hi;
  logic [7:0]  w_len_lo;
  logic [7:0]  w_cks_hi;
  logic [7:0]  w_cks_lo;

  // word arithmetic
  logic [15:0] w_len_base;
  logic [15:0] w_cks_base;
  logic [15:0] w_len_eff;
  logic [15:0] w_cks_eff;
  logic [16:0] w_lim;
  logic [19:0] w_word_sum;
  logic        w_last_hit;
  logic [31:0] w_acc_sum;

  // end-of-frame verdict inputs
  logic [15:0] w_fin_len;
  logic [15:0] w_fin_cks;
  logic        w_fin_last;
  logic        w_fin_err;
  logic        w_fin_zero;
  logic        w_fin_bad;
  logic [15:0] w_fold2;
  logic        w_verdict;

  // FSM-derived strobes
  logic        w_term_ld;
  logic        w_fold1_ld;
  logic        w_report_ld;

  // registers
  logic [31:0] r_acc;
  logic [31:0] r_hold;
  logic [16:0] r_s;
  logic [15:0] r_len;
  logic [15:0] r_cks;
  logic        r_open;
  logic        r_err;
  logic        r_last;
  logic        r_bad;
  logic        r_zero;
  logic        r_done;
  logic        r_pass;
  logic        r_fail;

  // Decode frame markers and locate the UDP length / checksum bytes in this word.
  always_comb begin
    w_gate     = chk_en_i & ipv6_flag_i & is_ptp_message_i;
    w_start    = rxc_i[0] & (rxd_i[7:0] == 8'hFB);
    w_term     = 1'b0;
    w_err      = 1'b0;
    w_dv       = 8'h00;
    w_len_hi_v = 1'b0;
    w_len_lo_v = 1'b0;
    w_cks_hi_v = 1'b0;
    w_cks_lo_v = 1'b0;
    w_len_hi   = 8'h00;
    w_len_lo   = 8'h00;
    w_cks_hi   = 8'h00;
    w_cks_lo   = 8'h00;
    for (int n = 0; n < 8; n++) begin
      w_cnt[n] = {1'b0, eth_count_base_i} + 12'(n);
      // bit 11 set means the lane lies before the IPv6 header
      w_k[n]   = w_cnt[n] - {1'b0, ipv6_addr_base_i};
      w_dv[n]  = w_gate & ~rxc_i[n] & ~w_k[n][11] & (w_cnt[n] <= 12'(MAX_FRAME));
      w_term   = w_term | (rxc_i[n] & (rxd_i[8*n +: 8] == 8'hFD));
      w_err    = w_err  | (rxc_i[n] & (rxd_i[8*n +: 8] == 8'hFE));
      case ({w_dv[n], w_k[n]})
        {1'b1, 12'd44}: begin w_len_hi_v = 1'b1; w_len_hi = rxd_i[8*n +: 8]; end
        {1'b1, 12'd45}: begin w_len_lo_v = 1'b1; w_len_lo = rxd_i[8*n +: 8]; end
        {1'b1, 12'd46}: begin w_cks_hi_v = 1'b1; w_cks_hi = rxd_i[8*n +: 8]; end
        {1'b1, 12'd47}: begin w_cks_lo_v = 1'b1; w_cks_lo = rxd_i[8*n +: 8]; end
        default: ;
      endcase
    end
  end

  // Sum this word's byte contributions; the UDP length may arrive in this same word.
  always_comb begin
    w_len_base = w_start ? 16'h0000 : r_len;
    w_cks_base = w_start ? 16'h0000 : r_cks;
    w_len_eff  = {w_len_hi_v ? w_len_hi : w_len_base[15:8],
                  w_len_lo_v ? w_len_lo : w_len_base[7:0]};
    w_cks_eff  = {w_cks_hi_v ? w_cks_hi : w_cks_base[15:8],
                  w_cks_lo_v ? w_cks_lo : w_cks_base[7:0]};
    w_lim      = 17'd40 + {1'b0, w_len_eff};
    // pseudo-header length joins the sum when its low byte is captured
    w_word_sum = w_len_lo_v ? {4'h0, w_len_eff} : 20'h00000;
    w_last_hit = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (w_dv[n] && (w_k[n] == 12'd6)) begin
        w_word_sum = w_word_sum + {12'h000, rxd_i[8*n +: 8]};
      end else if (w_dv[n] && (w_k[n] >= 12'd8) &&
                   ((w_k[n] <= 12'd47) || ({5'b00000, w_k[n]} < w_lim))) begin
        // header bytes up to k=47 always count; payload is bounded by the length
        w_word_sum = w_word_sum + (w_k[n][0] ? {12'h000, rxd_i[8*n +: 8]}
                                             : {4'h0, rxd_i[8*n +: 8], 8'h00});
      end else begin
        w_word_sum = w_word_sum;
      end
      w_last_hit = w_last_hit | (w_dv[n] & ({5'b00000, w_k[n]} == (w_lim - 17'd1)) &
                                 (w_len_eff >= 16'd8));
    end
    w_acc_sum = r_acc + {12'h000, w_word_sum};
  end

  // Collect the failure conditions of the frame that ends in this word.
  always_comb begin
    // with START in the same word the current bytes belong to the next frame
    w_fin_len  = w_start ? r_len : w_len_eff;
    w_fin_cks  = w_start ? r_cks : w_cks_eff;
    w_fin_last = r_last | (~w_start & w_last_hit);
    w_fin_err  = r_err | w_err;
    w_fin_zero = (w_fin_cks == 16'h0000);
    w_fin_bad  = w_fin_err | (w_fin_len < 16'd8) | ~w_fin_last | (w_fin_zero & ~ZERO_CHKSUM_OK);
    w_fold2    = r_s[15:0] + {15'h0000, r_s[16]};
    w_verdict  = ~r_bad & (r_zero | (w_fold2 == 16'hFFFF));
  end

  // FSM state register.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_state <= S_IDLE;
    end else if (rx_clk_en_i) begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; a START anywhere restarts accumulation.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = w_start ? S_ACCUM : S_IDLE;
      S_ACCUM: begin
        if (w_term && w_gate) begin
          w_state_nxt = S_FOLD1;
        end else if (w_term && !w_start) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_FOLD1:  w_state_nxt = w_start ? S_ACCUM : S_FOLD2;
      S_FOLD2:  w_state_nxt = w_start ? S_ACCUM : S_REPORT;
      // a back-to-back frame keeps accumulating while the previous one folds
      S_REPORT: w_state_nxt = (w_start || r_open) ? S_ACCUM : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode: load strobes for the fold pipeline and the verdict.
  always_comb begin
    w_term_ld   = (r_state == S_ACCUM) & w_term & w_gate;
    w_fold1_ld  = (r_state == S_FOLD1);
    w_report_ld = (r_state == S_FOLD2) & ~w_start;
  end

  // Accumulator, field capture and per-frame flags.
  // A TERMINATE arriving while a previous frame is still folding is dropped.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_acc  <= 32'h0000_0000;
      r_hold <= 32'h0000_0000;
      r_s    <= 17'h0_0000;
      r_len  <= 16'h0000;
      r_cks  <= 16'h0000;
      r_open <= 1'b0;
      r_err  <= 1'b0;
      r_last <= 1'b0;
      r_bad  <= 1'b0;
      r_zero <= 1'b0;
    end else if (rx_clk_en_i) begin
      if (w_start) begin
        r_open <= 1'b1;
        r_acc  <= {12'h000, w_word_sum};
        r_len  <= w_len_eff;
        r_cks  <= w_cks_eff;
        r_err  <= w_err;
        r_last <= w_last_hit;
      end else if (r_open) begin
        r_open <= ~w_term;
        r_acc  <= w_acc_sum;
        r_len  <= w_len_eff;
        r_cks  <= w_cks_eff;
        r_err  <= r_err | w_err;
        r_last <= r_last | w_last_hit;
      end
      if (w_term_ld) begin
        r_hold <= w_start ? r_acc : w_acc_sum;
        r_bad  <= w_fin_bad;
        r_zero <= w_fin_zero & ZERO_CHKSUM_OK;
      end
      if (w_fold1_ld) begin
        r_s <= {1'b0, r_hold[31:16]} + {1'b0, r_hold[15:0]};
      end
    end
  end

  // Registered result outputs: done pulses for one enabled cycle in REPORT.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else if (rx_clk_en_i) begin
      r_done <= w_report_ld;
      if (w_start) begin
        r_pass <= 1'b0;
        r_fail <= 1'b0;
      end else if (w_report_ld) begin
        r_pass <= w_verdict;
        r_fail <= ~w_verdict;
      end
    end
  end

  assign chk_done_o   = r_done;
  assign chk_pass_o   = r_pass;
  assign chk_fail_o   = r_fail;
  assign udp_length_o = r_len;
  assign rx_chksum_o  = r_cks;

endmodule

// File: tb/tb_ipv6_udp_chkvfy.sv
// tb_ipv6_udp_chkvfy: directed frames for the IPv6 UDP checksum verifier.
// Two instances share the stimulus: dut0 rejects a zero checksum, dut1 accepts it.
`timescale 1ns/1ps
module tb_ipv6_udp_chkvfy;

  localparam int IP_BASE = 22;  // 8 preamble/SFD bytes + 14-byte Ethernet header

  logic        rx_clk = 1'b0;
  logic        rx_rst_n;
  logic        rx_clk_en_i;
  logic        chk_en_i;
  logic [10:0] eth_count_base_i;
  logic        ipv6_flag_i;
  logic [10:0] ipv6_addr_base_i;
  logic        is_ptp_message_i;
  logic [63:0] rxd_i;
  logic [7:0]  rxc_i;
  logic        done0, pass0, fail0, done1, pass1, fail1;
  logic [15:0] len0, cks0, len1, cks1;

  logic [7:0]  fb [0:255];
  logic        fc [0:255];
  int          flen;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          en_edges = 0;
  int          done_cnt, done_at, term_edge;
  logic [15:0] cur_cks, good_cks;

  localparam logic [63:0] GARBAGE = 64'hFBFDFEFB_FBFDFEFB;
  localparam logic [63:0] IDLES   = 64'h07070707_07070707;

  always #5 rx_clk = ~rx_clk;

  ipv6_udp_chkvfy #(.ZERO_CHKSUM_OK(1'b0), .MAX_FRAME(2047)) dut0 (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_clk_en_i(rx_clk_en_i), .chk_en_i(chk_en_i),
    .eth_count_base_i(eth_count_base_i), .ipv6_flag_i(ipv6_flag_i),
    .ipv6_addr_base_i(ipv6_addr_base_i), .is_ptp_message_i(is_ptp_message_i),
    .rxd_i(rxd_i), .rxc_i(rxc_i), .chk_done_o(done0), .chk_pass_o(pass0),
    .chk_fail_o(fail0), .udp_length_o(len0), .rx_chksum_o(cks0));

  ipv6_udp_chkvfy #(.ZERO_CHKSUM_OK(1'b1), .MAX_FRAME(2047)) dut1 (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_clk_en_i(rx_clk_en_i), .chk_en_i(chk_en_i),
    .eth_count_base_i(eth_count_base_i), .ipv6_flag_i(ipv6_flag_i),
    .ipv6_addr_base_i(ipv6_addr_base_i), .is_ptp_message_i(is_ptp_message_i),
    .rxd_i(rxd_i), .rxc_i(rxc_i), .chk_done_o(done1), .chk_pass_o(pass1),
    .chk_fail_o(fail1), .udp_length_o(len1), .rx_chksum_o(cks1));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one word for one clock; counts enabled edges and done pulses of dut0.
  task automatic drive(input logic [63:0] d, input logic [7:0] c, input logic [10:0] base,
                       input logic en);
    rxd_i = d; rxc_i = c; eth_count_base_i = base; rx_clk_en_i = en;
    @(posedge rx_clk);
    if (en) en_edges++;
    #1;
    if (done0 && en) begin
      done_cnt++;
      if (done_at < 0) done_at = en_edges;
    end
  endtask

  // Build a PTP/UDP/IPv6 frame with a correct (or forced-zero) UDP checksum.
  task automatic build_frame(input int ulen, input int pad, input bit zero_cks);
    int          sum;
    logic [7:0]  lo;
    for (int i = 0; i < 256; i++) begin fb[i] = 8'h07; fc[i] = 1'b1; end
    fb[0] = 8'hFB;
    for (int i = 1; i < 7; i++) begin fb[i] = 8'h55; fc[i] = 1'b0; end
    fb[7] = 8'hD5; fc[7] = 1'b0;
    for (int i = 8; i < IP_BASE; i++) begin fb[i] = 8'(i * 7 + 3); fc[i] = 1'b0; end
    fb[20] = 8'h86; fb[21] = 8'hDD;
    for (int k = 0; k < 40 + ulen + pad + 4; k++) fc[IP_BASE + k] = 1'b0;
    fb[IP_BASE + 0] = 8'h60; fb[IP_BASE + 1] = 8'h00; fb[IP_BASE + 2] = 8'h00;
    fb[IP_BASE + 3] = 8'h00; fb[IP_BASE + 4] = 8'(ulen >> 8); fb[IP_BASE + 5] = 8'(ulen);
    fb[IP_BASE + 6] = 8'h11; fb[IP_BASE + 7] = 8'h40;
    for (int k = 8; k < 40; k++) fb[IP_BASE + k] = 8'(k * 29 + 11);
    fb[IP_BASE + 40] = 8'h01; fb[IP_BASE + 41] = 8'h3F;
    fb[IP_BASE + 42] = 8'h01; fb[IP_BASE + 43] = 8'h3F;
    fb[IP_BASE + 44] = 8'(ulen >> 8); fb[IP_BASE + 45] = 8'(ulen);
    fb[IP_BASE + 46] = 8'h00; fb[IP_BASE + 47] = 8'h00;
    for (int k = 48; k < 40 + ulen; k++) fb[IP_BASE + k] = 8'(k * 13 + 5);
    for (int k = 40 + ulen; k < 40 + ulen + pad; k++) fb[IP_BASE + k] = 8'hA5;
    fb[IP_BASE + 40 + ulen + pad + 0] = 8'hC3;
    fb[IP_BASE + 40 + ulen + pad + 1] = 8'h5A;
    fb[IP_BASE + 40 + ulen + pad + 2] = 8'h96;
    fb[IP_BASE + 40 + ulen + pad + 3] = 8'hE1;
    flen = IP_BASE + 40 + ulen + pad + 4;
    fb[flen] = 8'hFD;
    // RFC-style checksum: addresses, length, next header, UDP header and payload
    sum = 0;
    for (int k = 8; k < 40; k += 2) sum += {fb[IP_BASE + k], fb[IP_BASE + k + 1]};
    sum += ulen + 17;
    for (int k = 40; k < 40 + ulen; k += 2) begin
      lo = (k + 1 < 40 + ulen) ? fb[IP_BASE + k + 1] : 8'h00;
      sum += {fb[IP_BASE + k], lo};
    end
    while ((sum >> 16) != 0) sum = (sum & 32'h0000_FFFF) + (sum >> 16);
    cur_cks = ~sum[15:0];
    if (cur_cks == 16'h0000) cur_cks = 16'hFFFF;
    if (zero_cks) cur_cks = 16'h0000;
    fb[IP_BASE + 46] = cur_cks[15:8];
    fb[IP_BASE + 47] = cur_cks[7:0];
  endtask

  // Cut the frame short: TERMINATE at IPv6 offset k.
  task automatic truncate_at(input int k);
    flen = IP_BASE + k;
    for (int i = flen; i < 256; i++) begin fb[i] = 8'h07; fc[i] = 1'b1; end
    fb[flen] = 8'hFD;
  endtask

  task automatic send_words(input int w0, input int w1, input bit toggle);
    logic [63:0] d;
    logic [7:0]  c;
    for (int w = w0; w <= w1; w++) begin
      for (int l = 0; l < 8; l++) begin
        d[8*l +: 8] = fb[8*w + l];
        c[l]        = fc[8*w + l];
      end
      if (toggle && (w % 3 == 1)) begin
        drive(GARBAGE, 8'hFF, 11'h000, 1'b0);
        drive(GARBAGE, 8'hFF, 11'h000, 1'b0);
      end
      drive(d, c, 11'(8 * w), 1'b1);
      if (flen >= 8 * w && flen < 8 * w + 8) term_edge = en_edges;
    end
  endtask

  // Idle words; also the bounded wait for the result.
  task automatic send_tail(input bit toggle);
    for (int i = 0; i < 12; i++) begin
      if (toggle && (i % 2 == 0)) drive(GARBAGE, 8'hFF, 11'h000, 1'b0);
      drive(IDLES, 8'hFF, 11'h000, 1'b1);
    end
  endtask

  task automatic run_frame(input bit toggle);
    done_cnt = 0; done_at = -1; term_edge = -1;
    send_words(0, flen / 8, toggle);
    send_tail(toggle);
  endtask

  // done is visible during enabled cycle T+3, i.e. after the TERMINATE edge
  // plus two further enabled edges.
  task automatic check_frame(input string tag, input bit exp_pass, input logic [15:0] exp_len,
                             input logic [15:0] exp_cks);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_latency"}, done_at - term_edge, 2);
    check_eq({tag, "_pass"}, {31'd0, pass0}, {31'd0, exp_pass});
    check_eq({tag, "_fail"}, {31'd0, fail0}, {31'd0, ~exp_pass});
    check_eq({tag, "_udp_len"}, {16'd0, len0}, {16'd0, exp_len});
    check_eq({tag, "_rx_cks"}, {16'd0, cks0}, {16'd0, exp_cks});
  endtask

  initial begin
    rx_rst_n = 1'b0; rx_clk_en_i = 1'b1; chk_en_i = 1'b1; ipv6_flag_i = 1'b1;
    is_ptp_message_i = 1'b1; ipv6_addr_base_i = 11'(IP_BASE); eth_count_base_i = 11'h000;
    rxd_i = IDLES; rxc_i = 8'hFF;
    repeat (3) @(posedge rx_clk);
    #1;
    check_eq("rst_done", {31'd0, done0}, 32'd0);
    check_eq("rst_pass", {31'd0, pass0}, 32'd0);
    check_eq("rst_fail", {31'd0, fail0}, 32'd0);
    check_eq("rst_len",  {16'd0, len0},  32'd0);
    check_eq("rst_cks",  {16'd0, cks0},  32'd0);
    @(negedge rx_clk);
    rx_rst_n = 1'b1;

    // 1: good Sync frame, udp_length 52
    build_frame(52, 0, 1'b0);
    good_cks = cur_cks;
    run_frame(1'b0);
    check_frame("good52", 1'b1, 16'h0034, good_cks);

    // 2: one payload bit flipped at k=60, checksum field untouched
    build_frame(52, 0, 1'b0);
    fb[IP_BASE + 60] = fb[IP_BASE + 60] ^ 8'h04;
    run_frame(1'b0);
    check_frame("flip60", 1'b0, 16'h0034, good_cks);

    // 3: zero checksum field
    build_frame(52, 0, 1'b1);
    run_frame(1'b0);
    check_frame("zero_cks0", 1'b0, 16'h0034, 16'h0000);
    check_eq("zero_cks1_pass", {31'd0, pass1}, 32'd1);
    check_eq("zero_cks1_fail", {31'd0, fail1}, 32'd0);

    // 4: odd length 53 with 5 padding bytes
    build_frame(53, 5, 1'b0);
    run_frame(1'b0);
    check_frame("odd53_pad", 1'b1, 16'h0035, cur_cks);
    check_eq("odd53_dut1_pass", {31'd0, pass1}, 32'd1);

    // 5a: truncated at k=70
    build_frame(52, 0, 1'b0);
    truncate_at(70);
    run_frame(1'b0);
    check_frame("trunc70", 1'b0, 16'h0034, good_cks);

    // 5b: /E/ at k=50
    build_frame(52, 0, 1'b0);
    fb[IP_BASE + 50] = 8'hFE; fc[IP_BASE + 50] = 1'b1;
    run_frame(1'b0);
    check_frame("err50", 1'b0, 16'h0034, good_cks);

    // 6a: good frame with clock enable toggling throughout
    build_frame(52, 0, 1'b0);
    run_frame(1'b1);
    check_frame("clken_toggle", 1'b1, 16'h0034, good_cks);

    // 6b: reset asserted mid-accumulation, rest of the frame then streamed in
    build_frame(52, 0, 1'b0);
    done_cnt = 0; done_at = -1; term_edge = -1;
    send_words(0, 9, 1'b0);
    check_eq("pre_rst_len", {16'd0, len0}, 32'h34);
    #2 rx_rst_n = 1'b0;
    #2;
    check_eq("mid_rst_len",  {16'd0, len0},  32'd0);
    check_eq("mid_rst_cks",  {16'd0, cks0},  32'd0);
    check_eq("mid_rst_pass", {31'd0, pass0}, 32'd0);
    check_eq("mid_rst_fail", {31'd0, fail0}, 32'd0);
    @(negedge rx_clk);
    rx_rst_n = 1'b1;
    send_words(10, flen / 8, 1'b0);
    send_tail(1'b0);
    check_eq("post_rst_done_cnt", done_cnt, 0);
    check_eq("post_rst_pass", {31'd0, pass0}, 32'd0);
    check_eq("post_rst_fail", {31'd0, fail0}, 32'd0);

    // recovery after reset
    build_frame(52, 0, 1'b0);
    run_frame(1'b0);
    check_frame("after_rst", 1'b1, 16'h0034, good_cks);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
